// File: rtl/ln_int_search_pkg.sv
// Shared constants, state type and e^k threshold table for the ln range-reduction search.
package ln_pkg;

   localparam int unsigned LN_DATA_W = 12;
   localparam int unsigned LN_IDX_W  = 4;
   localparam int unsigned LN_THR_W  = 13;
   localparam int unsigned LN_DEPTH  = 16;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SEARCH = 2'd1,
      ST_DONE   = 2'd2
   } ln_state_e;

   typedef logic [LN_THR_W-1:0] ln_thr_t;

   // Rounded Q4.8 e^k, indexed by idx = k + 8; entries above idx 10 exceed any 12-bit x.
   localparam ln_thr_t LN_THRESH [LN_DEPTH] = '{
      13'd0,    13'd0,    13'd1,    13'd2,
      13'd5,    13'd13,   13'd35,   13'd94,
      13'd256,  13'd696,  13'd1892, 13'd4096,
      13'd4096, 13'd4096, 13'd4096, 13'd4096
   };

endpackage

// File: rtl/ln_int_search_if.sv
// Operand/result valid-ready bus for ln_int_search.
interface ln_int_search_if;
   import ln_pkg::*;

   logic                 in_valid;
   logic                 in_ready;
   logic [LN_DATA_W-1:0] in_x;
   logic                 out_valid;
   logic                 out_ready;
   logic [LN_IDX_W-1:0]  out_k;
   logic [LN_DATA_W-1:0] out_resid;
   logic                 out_zero;

   modport master (
      output in_valid, in_x, out_ready,
      input  in_ready, out_valid, out_k, out_resid, out_zero
   );

   modport slave (
      input  in_valid, in_x, out_ready,
      output in_ready, out_valid, out_k, out_resid, out_zero
   );

endinterface

// File: rtl/ln_thresh_rom.sv
// Combinational lookup of the e^k threshold for a table index.
module ln_thresh_rom
   import ln_pkg::*;
(
   input  logic [LN_IDX_W-1:0] i_idx,
   output ln_thr_t             o_thr
);

   assign o_thr = LN_THRESH[i_idx];

endmodule

// File: rtl/ln_int_search.sv
// Successive-approximation floor(ln x) search: one threshold compare per cycle,
// returns k in two's complement plus the residual x - T(k).
module ln_int_search
   import ln_pkg::*;
#(
   parameter int unsigned DATA_W = LN_DATA_W,
   parameter int unsigned IDX_W  = LN_IDX_W
) (
   input  logic           clk,
   input  logic           rst_n,
   ln_int_search_if.slave bus
);

   if (DATA_W != 12) begin : g_bad_data_w
      $error("ln_int_search: threshold table only defined for DATA_W == 12");
   end
   if (IDX_W != 4) begin : g_bad_idx_w
      $error("ln_int_search: IDX_W must be 4");
   end

   ln_state_e         r_state,     w_nxt_state;
   logic [DATA_W-1:0] r_x,         w_nxt_x;
   logic [IDX_W-1:0]  r_idx,       w_nxt_idx;
   logic [1:0]        r_bit,       w_nxt_bit;
   logic [DATA_W-1:0] r_thr,       w_nxt_thr;
   logic              r_in_ready,  w_nxt_in_ready;
   logic              r_out_valid, w_nxt_out_valid;
   logic [IDX_W-1:0]  r_out_k,     w_nxt_out_k;
   logic [DATA_W-1:0] r_out_resid, w_nxt_out_resid;
   logic              r_out_zero,  w_nxt_out_zero;

   logic [IDX_W-1:0]  w_trial;
   ln_thr_t           w_thr;
   logic              w_ge;
   logic [IDX_W-1:0]  w_fidx;
   logic [DATA_W-1:0] w_fthr;

   ln_thresh_rom u_rom (
      .i_idx (w_trial),
      .o_thr (w_thr)
   );

   // r_thr tracks T[r_idx] so the residual needs no second table lookup.
   assign w_trial = r_idx | (IDX_W'(1) << r_bit);
   assign w_ge    = {1'b0, r_x} >= w_thr;
   assign w_fidx  = w_ge ? w_trial : r_idx;
   assign w_fthr  = w_ge ? w_thr[DATA_W-1:0] : r_thr;

   always_comb begin
      w_nxt_state     = r_state;
      w_nxt_x         = r_x;
      w_nxt_idx       = r_idx;
      w_nxt_bit       = r_bit;
      w_nxt_thr       = r_thr;
      w_nxt_out_valid = r_out_valid;
      w_nxt_out_k     = r_out_k;
      w_nxt_out_resid = r_out_resid;
      w_nxt_out_zero  = r_out_zero;
      case (r_state)
         ST_IDLE: begin
            if (bus.in_valid && r_in_ready) begin
               w_nxt_state = ST_SEARCH;
               w_nxt_x     = bus.in_x;
               w_nxt_idx   = '0;
               w_nxt_bit   = 2'd3;
               w_nxt_thr   = '0;
            end
         end
         ST_SEARCH: begin
            w_nxt_idx = w_fidx;
            w_nxt_thr = w_fthr;
            w_nxt_bit = 2'(r_bit - 2'd1);
            if (r_bit == 2'd0) begin
               w_nxt_state     = ST_DONE;
               w_nxt_out_valid = 1'b1;
               w_nxt_out_k     = w_fidx ^ IDX_W'(8);
               w_nxt_out_resid = r_x - w_fthr;
               w_nxt_out_zero  = (r_x == '0);
            end
         end
         ST_DONE: begin
            if (bus.out_ready) begin
               w_nxt_state     = ST_IDLE;
               w_nxt_out_valid = 1'b0;
            end
         end
         default: w_nxt_state = ST_IDLE;
      endcase
      w_nxt_in_ready = (w_nxt_state == ST_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_x         <= '0;
         r_idx       <= '0;
         r_bit       <= '0;
         r_thr       <= '0;
         r_in_ready  <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_k     <= '0;
         r_out_resid <= '0;
         r_out_zero  <= 1'b0;
      end else begin
         r_state     <= w_nxt_state;
         r_x         <= w_nxt_x;
         r_idx       <= w_nxt_idx;
         r_bit       <= w_nxt_bit;
         r_thr       <= w_nxt_thr;
         r_in_ready  <= w_nxt_in_ready;
         r_out_valid <= w_nxt_out_valid;
         r_out_k     <= w_nxt_out_k;
         r_out_resid <= w_nxt_out_resid;
         r_out_zero  <= w_nxt_out_zero;
      end
   end

   assign bus.in_ready  = r_in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.out_k     = r_out_k;
   assign bus.out_resid = r_out_resid;
   assign bus.out_zero  = r_out_zero;

endmodule

// File: tb/tb_ln_int_search.sv
// Randomized self-checking bench for ln_int_search against a table-scan reference.
module tb_ln_int_search;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_errors;

   ln_int_search_if u_if ();

   ln_int_search u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (u_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int T_REF [16] = '{0, 0, 1, 2, 5, 13, 35, 94, 256, 696, 1892,
                      4096, 4096, 4096, 4096, 4096};

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // Largest table index whose e^k threshold does not exceed x.
   function automatic int ref_idx(input int x);
      int best = 0;
      for (int i = 0; i < 16; i++) if (T_REF[i] <= x) best = i;
      return best;
   endfunction

   task automatic do_txn(input int x, input int stall);
      int         n;
      int         idx;
      int         kv;
      logic [3:0] ek;
      idx = ref_idx(x);
      kv  = idx - 8;
      ek  = 4'(kv);
      u_if.out_ready = (stall == 0);
      n = 0;
      while (!u_if.in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("in_ready_wait", 32'(u_if.in_ready), 32'd1);
      u_if.in_valid = 1'b1;
      u_if.in_x     = 12'(x);
      @(negedge clk);
      u_if.in_valid = 1'b0;
      u_if.in_x     = 12'($urandom_range(0, 4095));
      n = 0;
      while (!u_if.out_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("latency", 32'(n), 32'd4);
      chk("out_k", 32'(u_if.out_k), 32'(ek));
      chk("out_resid", 32'(u_if.out_resid), 32'(x - T_REF[idx]));
      chk("out_zero", 32'(u_if.out_zero), 32'(x == 0));
      chk("k_range", 32'(kv >= -7 && kv <= 2 &&
                         $signed(u_if.out_k) >= -4'sd7 && $signed(u_if.out_k) <= 4'sd2), 32'd1);
      for (int i = 0; i < stall; i++) begin
         u_if.in_valid = 1'b1;
         u_if.in_x     = 12'($urandom_range(0, 4095));
         @(negedge clk);
         chk("hold_valid", 32'(u_if.out_valid), 32'd1);
         chk("hold_k", 32'(u_if.out_k), 32'(ek));
         chk("hold_resid", 32'(u_if.out_resid), 32'(x - T_REF[idx]));
         chk("hold_in_ready", 32'(u_if.in_ready), 32'd0);
      end
      u_if.in_valid  = 1'b0;
      u_if.out_ready = 1'b1;
      @(negedge clk);
      chk("post_hs_valid", 32'(u_if.out_valid), 32'd0);
      chk("post_hs_in_ready", 32'(u_if.in_ready), 32'd1);
      u_if.out_ready = 1'b0;
   endtask

   initial begin
      n_checks       = 0;
      n_errors       = 0;
      rst_n          = 1'b0;
      u_if.in_valid  = 1'b0;
      u_if.in_x      = '0;
      u_if.out_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_in_ready", 32'(u_if.in_ready), 32'd0);
      chk("rst_out_valid", 32'(u_if.out_valid), 32'd0);
      chk("rst_out_k", 32'(u_if.out_k), 32'd0);
      chk("rst_out_resid", 32'(u_if.out_resid), 32'd0);
      chk("rst_out_zero", 32'(u_if.out_zero), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      do_txn(256, 0);
      do_txn(255, 0);
      do_txn(696, 0);
      do_txn(4095, 0);
      do_txn(0, 0);
      do_txn(1, 0);
      do_txn(100, 10);

      // Abort a search two cycles in; leave stale nonzero outputs from the prior result.
      do_txn(4095, 0);
      u_if.in_valid = 1'b1;
      u_if.in_x     = 12'd3000;
      @(negedge clk);
      u_if.in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("abort_in_ready", 32'(u_if.in_ready), 32'd0);
      chk("abort_out_valid", 32'(u_if.out_valid), 32'd0);
      chk("abort_out_k", 32'(u_if.out_k), 32'd0);
      chk("abort_out_resid", 32'(u_if.out_resid), 32'd0);
      chk("abort_out_zero", 32'(u_if.out_zero), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      do_txn(13, 0);

      for (int x = 0; x < 4096; x++) do_txn(x, 0);

      for (int i = 0; i < 150; i++) begin
         int x;
         if ($urandom_range(0, 3) == 0)
            x = T_REF[$urandom_range(0, 10)] + int'($urandom_range(0, 2)) - 1;
         else
            x = int'($urandom_range(0, 4095));
         if (x < 0) x = 0;
         do_txn(x, int'($urandom_range(0, 4)));
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/ln_int_search.md
Name: ln_int_search

Overview:
- Inverse of the exp-scale lookup: takes an unsigned Q4.8 magnitude x and returns k = floor(ln(x)) as a 4-bit two's-complement integer. k uses the same encoding as the exp_int input of the exp-scale stage.
- Also returns the residual x − T(k), where T(k) is the rounded Q4.8 value of e^k.
- Sits ahead of the exp/log datapath in the 8b_frac PE for range reduction.
- Sequential successive-approximation search: one threshold compare per cycle, valid/ready on both sides.

Parameters:
- DATA_W, 12, input/residual width in Q4.8. The threshold table is defined only for 12; elaborate-time assert otherwise.
- IDX_W, 4, result width; 16 entries, k = −8..7. Elaborate-time assert IDX_W == 4.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input x valid
- in_ready  out  1  block can accept x
- in_x  in  DATA_W  unsigned Q4.8 operand
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_k  out  IDX_W  floor(ln x), two's complement
- out_resid  out  DATA_W  in_x − T(out_k), unsigned
- out_zero  out  1  in_x was 0; out_k is clamped

Behaviour:
- Reset (async, rst_n=0): state=IDLE; in_ready=0 during reset, then 1 in IDLE. out_valid, out_k, out_resid, out_zero, internal x/idx/bit counter all 0. Reset mid-search or in DONE aborts immediately; the result is lost.
- Threshold table T[idx] is 13-bit unsigned, with k = idx − 8 (i.e. k = idx XOR 4'b1000):
  - idx 0..7: 0, 0, 1, 2, 5, 13, 35, 94
  - idx 8..10: 256, 696, 1892
  - idx 11..15: 4096 (unreachable by a 12-bit x)
  - T is non-decreasing and T[0] = 0.
- States:
  - IDLE: in_ready=1. On in_valid & in_ready, capture x, set idx=0, bit=3, go to SEARCH.
  - SEARCH: each cycle, trial = idx | (1<<bit). If {1'b0,x} >= T[trial], idx = trial. Decrement bit. After bit 0 is resolved, go to DONE and register outputs.
  - DONE: out_valid=1; outputs held stable. On out_ready, go to IDLE and drop out_valid.
- Latency: acceptance edge E0, then 4 SEARCH edges. out_valid rises on E4, i.e. 4 cycles after acceptance.
- Throughput: in_ready=0 in SEARCH and DONE, so there is no overlap. Minimum one result per 6 cycles with out_ready held high.
- Result: idx is the largest index with T[idx] <= x.
  - out_k = idx XOR 4'b1000.
  - out_resid = x − T[idx][11:0]; never negative, no wrap.
  - out_zero = (x == 0).
- Boundaries:
  - x=0: T[0] = T[1] = 0, so idx=1, out_k = −7 (4'b1001), resid 0, out_zero=1.
  - x >= 1892: out_k = 2 (max reachable). k = 3..7 and k = −8 are never produced.
  - out_ready held low: DONE holds indefinitely with stable outputs.
  - in_valid while busy: ignored and not captured; in_x need not be held.
- All outputs are registered; there are no combinational in-to-out paths.

Decomposition:
- Package ln_pkg:
  - DATA_W/IDX_W constants
  - typedef enum logic [1:0] {IDLE, SEARCH, DONE}
  - typedef for the 13-bit threshold
  - localparam array LN_THRESH[16] holding the table above
- Sub-module ln_thresh_rom: combinational, 4-bit idx in, 13-bit threshold out, indexed from LN_THRESH. Instantiated once on the trial index.
- Top module: FSM, idx/bit counters, compare, subtract, handshake.

Test Plan:
- x=256, out_ready=1 -> out_valid exactly 4 cycles after acceptance; out_k=4'b0000, out_resid=0, out_zero=0; in_ready back to 1 the cycle after output handshake.
- x=255; x=696; x=4095 -> out_k=4'b1111 resid=161; out_k=4'b0001 resid=0; out_k=4'b0010 resid=2203.
- x=0 -> out_k=4'b1001, out_resid=0, out_zero=1. Then x=1 -> out_k=4'b1010 (−6), resid=0, out_zero=0.
- Backpressure: x=100, out_ready=0 for 10 cycles, in_valid=1 with changing in_x throughout -> out_k=4'b1111, resid=6 held stable; in_ready=0; no extra capture. Release out_ready -> single handshake, then IDLE.
- Reset mid-operation: assert rst_n=0 at SEARCH cycle 2 -> all outputs 0 asynchronously. After release, x=13 -> out_k=4'b1101 (−3), resid=0.
- Sweep x=0..4095 against a golden model (largest idx with T[idx] <= x) -> all match; out_k always in −7..2.
